// File: rtl/debounce_multi.sv
// Purpose : CH-channel switch debouncer (lockout or integrating mode) with rise/fall ticks.
// Latency : lockout 1 cycle, integrating 2^N+1 cycles, plus 2 when DEBOUNCE_SYNC_EN is defined.
// Backpressure: none; free-running and consumes one sample per clock per channel.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   sw[CH]     raw switch levels
//   db_level   registered debounced level per channel
//   rise_tick  one-cycle pulse in the first cycle db_level[i] reads 1
//   fall_tick  one-cycle pulse in the first cycle db_level[i] reads 0
//
// Optional feature macro: DEBOUNCE_SYNC_EN
//   When defined, each sw bit passes through a two-flop synchroniser first.
module debounce_multi #(
    parameter int CH   = 4,
    parameter int N    = 21,
    parameter int MODE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] sw,
    output logic [CH-1:0] db_level,
    output logic [CH-1:0] rise_tick,
    output logic [CH-1:0] fall_tick
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam logic [N-1:0] LOAD = {N{1'b1}};
    localparam logic [N-1:0] DEC  = N'(1);

    // Sampled input seen by the per-channel FSMs.
    logic [CH-1:0] s;

`ifdef DEBOUNCE_SYNC_EN
    logic [CH-1:0] sync_ff1;
    logic [CH-1:0] sync_ff2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff1 <= '0;
            sync_ff2 <= '0;
        end else begin
            sync_ff1 <= sw;
            sync_ff2 <= sync_ff1;
        end
    end

    assign s = sync_ff2;
`else
    assign s = sw;
`endif

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t         state_q;
        state_t         state_n;
        logic [N-1:0]   q_q;
        logic [N-1:0]   q_n;
        logic           db_q;
        logic           db_n;
        logic           rise_q;
        logic           fall_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= ZERO;
                q_q     <= '0;
                db_q    <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_n;
                q_q     <= q_n;
                db_q    <= db_n;
                // Ticks line up with the first cycle the new level is visible.
                rise_q  <= db_n & ~db_q;
                fall_q  <= ~db_n & db_q;
            end
        end

        always_comb begin
            state_n = state_q;
            q_n     = q_q;
            db_n    = db_q;
            case (state_q)
                ZERO: begin
                    if (s[i]) begin
                        q_n     = LOAD;
                        state_n = WAIT1;
                        if (MODE == 0) begin
                            db_n = 1'b1;
                        end
                    end
                end
                WAIT1: begin
                    if (MODE == 0) begin
                        // Lockout: input ignored until the interval expires.
                        if (q_q == '0) begin
                            state_n = ONE;
                        end else begin
                            q_n = q_q - DEC;
                        end
                    end else begin
                        // Integrating: any low sample aborts; level changes only
                        // once the counter has drained with the input still high.
                        if (!s[i]) begin
                            state_n = ZERO;
                        end else if (q_q == '0) begin
                            state_n = ONE;
                            db_n    = 1'b1;
                        end else begin
                            q_n = q_q - DEC;
                        end
                    end
                end
                ONE: begin
                    if (!s[i]) begin
                        q_n     = LOAD;
                        state_n = WAIT0;
                        if (MODE == 0) begin
                            db_n = 1'b0;
                        end
                    end
                end
                WAIT0: begin
                    if (MODE == 0) begin
                        if (q_q == '0) begin
                            state_n = ZERO;
                        end else begin
                            q_n = q_q - DEC;
                        end
                    end else begin
                        if (s[i]) begin
                            state_n = ONE;
                        end else if (q_q == '0) begin
                            state_n = ZERO;
                            db_n    = 1'b0;
                        end else begin
                            q_n = q_q - DEC;
                        end
                    end
                end
                default: begin
                    state_n = ZERO;
                end
            endcase
        end

        assign db_level[i]  = db_q;
        assign rise_tick[i] = rise_q;
        assign fall_tick[i] = fall_q;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Purpose : directed check of debounce_multi in lockout and integrating modes.
// Latency : expectations measured in rising edges from the negedge sw is driven.
// Backpressure: none; two DUT instances (MODE 0 and MODE 1) share sw and reset.
module tb_debounce_multi;

    localparam int CH = 4;
    localparam int N  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] sw;
    logic [CH-1:0] db0, rise0, fall0;
    logic [CH-1:0] db1, rise1, fall1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    debounce_multi #(.CH(CH), .N(N), .MODE(0)) dut_lock (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .db_level  (db0),
        .rise_tick (rise0),
        .fall_tick (fall0)
    );

    debounce_multi #(.CH(CH), .N(N), .MODE(1)) dut_integ (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .db_level  (db1),
        .rise_tick (rise1),
        .fall_tick (fall1)
    );

    // Leaves the bench at a negedge with reset low and sw = 0.
    task automatic do_reset();
        @(negedge clk);
        sw    = '0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        sw    = 4'b1111;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (db0 !== 4'b0000) begin bad++; $display("FAIL reset_db0 got=%b exp=0000", db0); end
        total++;
        if ({rise0, fall0} !== 8'h00) begin bad++; $display("FAIL reset_ticks0 got=%b/%b exp=0000/0000", rise0, fall0); end
        total++;
        if (db1 !== 4'b0000) begin bad++; $display("FAIL reset_db1 got=%b exp=0000", db1); end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (db0 !== 4'b1111) begin bad++; $display("FAIL reset_rearm_db0 got=%b exp=1111", db0); end
        total++;
        if (rise0 !== 4'b1111) begin bad++; $display("FAIL reset_rearm_rise0 got=%b exp=1111", rise0); end
        @(negedge clk);
        total++;
        if (rise0 !== 4'b0000) begin bad++; $display("FAIL reset_rise_oneshot got=%b exp=0000", rise0); end
        total++;
        if (db1 !== 4'b0000) begin bad++; $display("FAIL reset_integ_still_low got=%b exp=0000", db1); end
    endtask

    task automatic test_lockout_bounce();
        logic [19:0] pat;
        int n_rise, n_fall, rise_at, fall_at;
        logic exp_db;
        // Bit k-1 is the sw[0] level sampled at edge k: rise, six toggles, then 0.
        pat = 20'b0000_0000_0000_0101_0101;
        n_rise = 0; n_fall = 0; rise_at = -1; fall_at = -1;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            sw[0] = pat[k-1];
            @(negedge clk);
            exp_db = (k >= 1 && k <= 9);
            total++;
            if (db0[0] !== exp_db) begin bad++; $display("FAIL lock_bounce_db k=%0d got=%b exp=%b", k, db0[0], exp_db); end
            if (rise0[0] === 1'b1) begin n_rise++; rise_at = k; end
            if (fall0[0] === 1'b1) begin n_fall++; fall_at = k; end
        end
        total++;
        if (n_rise != 1 || rise_at != 1) begin bad++; $display("FAIL lock_bounce_rise count=%0d at=%0d exp=1 at 1", n_rise, rise_at); end
        total++;
        if (n_fall != 1 || fall_at != 10) begin bad++; $display("FAIL lock_bounce_fall count=%0d at=%0d exp=1 at 10", n_fall, fall_at); end
    endtask

    task automatic test_integ_stable();
        int first_hi, n_rise;
        logic [CH-1:0] others;
        first_hi = -1; n_rise = 0; others = '0;
        do_reset();
        sw[1] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (db1[1] === 1'b1 && first_hi < 0) first_hi = k;
            if (rise1[1] === 1'b1) n_rise++;
            others = others | (db1 & 4'b1101);
        end
        total++;
        if (first_hi != 9) begin bad++; $display("FAIL integ_stable_latency got=%0d exp=9", first_hi); end
        total++;
        if (n_rise != 1) begin bad++; $display("FAIL integ_stable_rise_count got=%0d exp=1", n_rise); end
        total++;
        if (others !== 4'b0000) begin bad++; $display("FAIL integ_stable_others got=%b exp=0000", others); end
        sw[1] = 1'b0;
    endtask

    task automatic test_integ_abort();
        logic exp_db;
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            sw[2] = (k != 7);
            @(negedge clk);
            exp_db = (k >= 16);
            total++;
            if (db1[2] !== exp_db) begin bad++; $display("FAIL integ_abort_db k=%0d got=%b exp=%b", k, db1[2], exp_db); end
            if (k == 16) begin
                total++;
                if (rise1[2] !== 1'b1) begin bad++; $display("FAIL integ_abort_rise got=%b exp=1", rise1[2]); end
            end
        end
        sw[2] = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        sw[3] = 1'b1;
        @(negedge clk);
        total++;
        if (db0[3] !== 1'b1) begin bad++; $display("FAIL midwait_first_rise got=%b exp=1", db0[3]); end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({db0[3], rise0[3]} !== 2'b00) begin bad++; $display("FAIL midwait_in_reset got=%b exp=00", {db0[3], rise0[3]}); end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({db0[3], rise0[3]} !== 2'b11) begin bad++; $display("FAIL midwait_rerise got=%b exp=11", {db0[3], rise0[3]}); end
        @(negedge clk);
        total++;
        if ({db0[3], rise0[3]} !== 2'b10) begin bad++; $display("FAIL midwait_tick_clear got=%b exp=10", {db0[3], rise0[3]}); end
        sw[3] = 1'b0;
    endtask

    task automatic test_sync();
        int lat, exp_lat;
`ifdef DEBOUNCE_SYNC_EN
        exp_lat = 3;
`else
        exp_lat = 1;
`endif
        lat = -1;
        do_reset();
        sw[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (db0[0] === 1'b1 && lat < 0) lat = k;
        end
        total++;
        if (lat != exp_lat) begin bad++; $display("FAIL sync_latency got=%0d exp=%0d", lat, exp_lat); end
        sw[0] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        sw    = '0;
        test_reset();
        test_lockout_bounce();
        test_integ_stable();
        test_integ_abort();
        test_reset_mid_wait();
        test_sync();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
